axis_packet_arbiter: RTL and testbench
======================================

Name: axis_packet_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one AXI-Stream message sink between N packet sources, e.g. several axis_send_packet-style message generators feeding one UART/stream sink.
- The grant is held from first beat to the beat with last=1, so packets are never interleaved.
- Sits between the message sources and the single downstream consumer; the output datapath is combinational pass-through of the granted source.

Parameters:
- DW, 8, data width of every source and of the output stream
- N, 2, number of requesting sources (N >= 2)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_msg_data  in  N*DW  source data; source k at bits [k*DW +: DW]
- i_msg_last  in  N  per-source last-beat flag
- i_msg_valid  in  N  per-source valid
- o_msg_ready  out  N  per-source ready
- o_msg_data  out  DW  arbitrated data
- o_msg_last  out  1  arbitrated last
- o_msg_valid  out  1  arbitrated valid
- i_msg_ready  in  1  downstream ready
- o_grant  out  N  one-hot current owner, all zero when idle
- o_busy  out  1  high while a packet is owned (state BUSY)

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is synchronous, active-high.
- Reset values:
  - state IDLE, o_grant=0, o_busy=0
  - priority pointer set so source 0 has highest priority (last owner = N-1)
  - o_msg_valid=0, o_msg_ready=0, o_msg_data=0, o_msg_last=0
- Reset mid-packet aborts ownership immediately; the next cycle is IDLE with the pointer reset.
- State IDLE:
  - o_msg_ready all 0, o_msg_valid=0.
  - If any i_msg_valid is set, select the first requester scanning (last_owner+1) mod N upward with wrap. Register it into o_grant and go to BUSY.
  - If none is set, stay in IDLE.
- State BUSY, owner g:
  - o_msg_data=i_msg_data[g], o_msg_last=i_msg_last[g], o_msg_valid=i_msg_valid[g].
  - o_msg_ready[g]=i_msg_ready; all other o_msg_ready bits are 0.
  - A beat transfers when o_msg_valid & i_msg_ready.
  - A transfer with o_msg_last=1 ends the packet: next state IDLE, o_grant=0, last_owner=g.
  - Owner deasserting valid mid-packet keeps the grant (no timeout).
- Latency:
  - One IDLE arbitration cycle precedes each packet.
  - First beat of a packet can transfer at the earliest 1 cycle after its valid is first seen in IDLE.
  - Back-to-back packets therefore have exactly one bubble cycle between them.
- Fairness: an owner becomes lowest priority after its packet, so with all N requesting continuously, grants rotate 0,1,...,N-1,0.
- Single-beat packets (last=1 on first beat) take 2 cycles total: IDLE then BUSY with transfer.
- Non-granted sources see ready=0 and must hold their data.
- Output data of non-owners never appears on o_msg_data.
- The pointer is $clog2(N) bits; wrap from N-1 to 0 is explicit, N need not be a power of two.

Test Plan:
1. Reset, then source 0 only sends "ab" (0x61,0x62, last on 2nd), i_msg_ready=1: o_grant=01 one cycle after valid; output 0x61 then 0x62 with last; o_busy drops the cycle after; o_msg_ready[1] stays 0 throughout.
2. N=3, all three sources hold 2-beat packets valid continuously, sink ready: grant order 0,1,2,0. One idle bubble between packets; no interleaved beats.
3. Sources 0 and 1 request, sink ready toggles 1,0,1,0: packet 0 bytes stall while ready=0 and are each transferred exactly once, in order. Source 1 is not granted until after source 0's last beat.
4. Owner 1 drops valid for 3 cycles mid-packet while source 0 requests: grant stays 010, o_msg_valid=0 during the gap, packet 1 then completes, then source 0 is granted.
5. Assert i_rst for 1 cycle in BUSY after first beat of source 1: next cycle o_grant=0, o_busy=0, o_msg_valid=0. With sources 0 and 1 both requesting, source 0 is granted first.
6. N=3, single-beat packets from sources 2 then 0 (last=1, data 0x7A, 0x41): each takes 2 cycles. After source 2's grant, source 0 wins over a simultaneous source 2 request (pointer wrap check).

Source files
------------

// File: rtl/axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_packet_arbiter
//
// Packet-atomic round-robin arbiter that shares one AXI-Stream style sink
// between N packet sources. Ownership is taken in IDLE (one arbitration cycle)
// and held in BUSY until the owner's beat with last=1 transfers, so packets
// never interleave. The output datapath is a combinational pass-through of
// the current owner.
//
// Parameters:
//   DW - data width of every source and of the output stream
//   N  - number of requesting sources (N >= 2)
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_msg_data   source data, source k at [k*DW +: DW]
//   i_msg_last   per-source last-beat flag
//   i_msg_valid  per-source valid
//   o_msg_ready  per-source ready (only the owner's bit can be set)
//   o_msg_data   arbitrated data (zero while idle)
//   o_msg_last   arbitrated last
//   o_msg_valid  arbitrated valid
//   i_msg_ready  downstream ready
//   o_grant      one-hot current owner, all zero when idle
//   o_busy       high while a packet is owned
// -----------------------------------------------------------------------------
module axis_packet_arbiter #(
    parameter int DW = 8,
    parameter int N  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N*DW-1:0] i_msg_data,
    input  logic [N-1:0]    i_msg_last,
    input  logic [N-1:0]    i_msg_valid,
    output logic [N-1:0]    o_msg_ready,
    output logic [DW-1:0]   o_msg_data,
    output logic            o_msg_last,
    output logic            o_msg_valid,
    input  logic            i_msg_ready,
    output logic [N-1:0]    o_grant,
    output logic            o_busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   last_owner_q, last_owner_d;

    logic            found_hi_s, found_lo_s;
    logic [PW-1:0]   sel_hi_s, sel_lo_s, sel_s;
    logic            end_of_pkt_s;

    // Round-robin pick: the first requester above the last owner wins; if
    // there is none, wrap and take the first requester at or below it.
    always_comb begin
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        sel_hi_s   = '0;
        sel_lo_s   = '0;
        for (int k = 0; k < N; k++) begin
            sel_hi_s   = (i_msg_valid[k] && !found_hi_s && (PW'(k) > last_owner_q)) ? PW'(k) : sel_hi_s;
            found_hi_s = found_hi_s | (i_msg_valid[k] && (PW'(k) > last_owner_q));
            sel_lo_s   = (i_msg_valid[k] && !found_lo_s && (PW'(k) <= last_owner_q)) ? PW'(k) : sel_lo_s;
            found_lo_s = found_lo_s | (i_msg_valid[k] && (PW'(k) <= last_owner_q));
        end
        sel_s = found_hi_s ? sel_hi_s : sel_lo_s;
    end

    // Next-state logic and owner-steered output datapath.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        o_msg_ready  = '0;
        o_msg_data   = '0;
        o_msg_last   = 1'b0;
        o_msg_valid  = 1'b0;
        end_of_pkt_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|i_msg_valid) begin
                    state_d = ST_BUSY;
                    owner_d = sel_s;
                    for (int k = 0; k < N; k++) begin
                        grant_d[k] = (sel_s == PW'(k));
                    end
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            ST_BUSY: begin
                for (int k = 0; k < N; k++) begin
                    o_msg_data     = (owner_q == PW'(k)) ? i_msg_data[k*DW +: DW] : o_msg_data;
                    o_msg_last     = (owner_q == PW'(k)) ? i_msg_last[k]  : o_msg_last;
                    o_msg_valid    = (owner_q == PW'(k)) ? i_msg_valid[k] : o_msg_valid;
                    o_msg_ready[k] = (owner_q == PW'(k)) & i_msg_ready;
                end
                // A dropped owner valid simply stalls; only a last-beat
                // transfer releases the grant.
                end_of_pkt_s = o_msg_valid & i_msg_ready & o_msg_last;
                if (end_of_pkt_s) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant and priority pointer registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q == ST_BUSY);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_packet_arbiter
//
// Self-checking bench for axis_packet_arbiter with N=3, DW=8. A table of
// cycle vectors checks every output each cycle; a scoreboard queue checks
// transferred beats; a hand-written source-model sequence covers ready
// toggling with two competing packets.
// -----------------------------------------------------------------------------
module tb_axis_packet_arbiter;

    localparam int DW = 8;
    localparam int N  = 3;

    logic            clk;
    logic            rst;
    logic [N*DW-1:0] msg_data;
    logic [N-1:0]    msg_last;
    logic [N-1:0]    msg_valid;
    logic [N-1:0]    msg_ready_o;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_valid;
    logic            sink_ready;
    logic [N-1:0]    grant;
    logic            busy;

    axis_packet_arbiter #(.DW(DW), .N(N)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_msg_data  (msg_data),
        .i_msg_last  (msg_last),
        .i_msg_valid (msg_valid),
        .o_msg_ready (msg_ready_o),
        .o_msg_data  (out_data),
        .o_msg_last  (out_last),
        .o_msg_valid (out_valid),
        .i_msg_ready (sink_ready),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic [2:0] vld;
        logic [2:0] lst;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [2:0] e_gnt;
        logic       e_busy;
        logic       e_vld;
        logic [7:0] e_dat;
        logic       e_lst;
        logic [2:0] e_rdy;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    vec_t  tbl[$];
    beat_t sb[$];
    beat_t s0[$];
    beat_t s1[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rdy, input logic [2:0] vld, input logic [2:0] lst,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [2:0] eg, input logic eb, input logic ev, input logic [7:0] ed,
                       input logic el, input logic [2:0] er);
        vec_t v;
        v.rst = r;   v.rdy = rdy; v.vld = vld; v.lst = lst;
        v.d0 = d0;   v.d1 = d1;   v.d2 = d2;
        v.e_gnt = eg; v.e_busy = eb; v.e_vld = ev; v.e_dat = ed; v.e_lst = el; v.e_rdy = er;
        tbl.push_back(v);
    endtask

    // A cycle in which the arbiter is idle: every output must be zero.
    task automatic idle(input logic r, input logic rdy, input logic [2:0] vld, input logic [2:0] lst,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        add(r, rdy, vld, lst, d0, d1, d2, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
    endtask

    task automatic drive_sources();
        msg_valid = 3'b000;
        msg_last  = 3'b000;
        msg_data  = '0;
        if (s0.size() > 0) begin
            msg_valid[0]   = 1'b1;
            msg_data[7:0]  = s0[0].d;
            msg_last[0]    = s0[0].l;
        end
        if (s1.size() > 0) begin
            msg_valid[1]   = 1'b1;
            msg_data[15:8] = s1[0].d;
            msg_last[1]    = s1[0].l;
        end
    endtask

    initial begin
        beat_t b;
        bit    pop0, pop1, src0_done;
        int    n_out;

        rst        = 1'b1;
        sink_ready = 1'b0;
        msg_valid  = 3'b000;
        msg_last   = 3'b000;
        msg_data   = '0;
        repeat (2) @(posedge clk);

        // Test 1: source 0 sends "ab".
        idle(1'b0, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
        idle(1'b0, 1'b1, 3'b001, 3'b000, 8'h61, 8'h00, 8'h00);
        add (1'b0, 1'b1, 3'b001, 3'b000, 8'h61, 8'h00, 8'h00, 3'b001, 1'b1, 1'b1, 8'h61, 1'b0, 3'b001);
        add (1'b0, 1'b1, 3'b001, 3'b001, 8'h62, 8'h00, 8'h00, 3'b001, 1'b1, 1'b1, 8'h62, 1'b1, 3'b001);
        idle(1'b0, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
        // Test 2: reset, then all three request continuously; grants 0,1,2,0.
        idle(1'b1, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
        idle(1'b0, 1'b1, 3'b111, 3'b000, 8'h10, 8'h20, 8'h30);
        add (1'b0, 1'b1, 3'b111, 3'b000, 8'h10, 8'h20, 8'h30, 3'b001, 1'b1, 1'b1, 8'h10, 1'b0, 3'b001);
        add (1'b0, 1'b1, 3'b111, 3'b001, 8'h11, 8'h20, 8'h30, 3'b001, 1'b1, 1'b1, 8'h11, 1'b1, 3'b001);
        idle(1'b0, 1'b1, 3'b111, 3'b000, 8'h12, 8'h20, 8'h30);
        add (1'b0, 1'b1, 3'b111, 3'b000, 8'h12, 8'h20, 8'h30, 3'b010, 1'b1, 1'b1, 8'h20, 1'b0, 3'b010);
        add (1'b0, 1'b1, 3'b111, 3'b010, 8'h12, 8'h21, 8'h30, 3'b010, 1'b1, 1'b1, 8'h21, 1'b1, 3'b010);
        idle(1'b0, 1'b1, 3'b111, 3'b000, 8'h12, 8'h22, 8'h30);
        add (1'b0, 1'b1, 3'b111, 3'b000, 8'h12, 8'h22, 8'h30, 3'b100, 1'b1, 1'b1, 8'h30, 1'b0, 3'b100);
        add (1'b0, 1'b1, 3'b111, 3'b100, 8'h12, 8'h22, 8'h31, 3'b100, 1'b1, 1'b1, 8'h31, 1'b1, 3'b100);
        idle(1'b0, 1'b1, 3'b111, 3'b000, 8'h12, 8'h22, 8'h32);
        add (1'b0, 1'b1, 3'b111, 3'b000, 8'h12, 8'h22, 8'h32, 3'b001, 1'b1, 1'b1, 8'h12, 1'b0, 3'b001);
        add (1'b0, 1'b1, 3'b111, 3'b001, 8'h13, 8'h22, 8'h32, 3'b001, 1'b1, 1'b1, 8'h13, 1'b1, 3'b001);
        idle(1'b0, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
        // Test 4: owner 1 drops valid for 3 cycles while source 0 waits.
        idle(1'b0, 1'b1, 3'b011, 3'b000, 8'h50, 8'h40, 8'h00);
        add (1'b0, 1'b1, 3'b011, 3'b000, 8'h50, 8'h40, 8'h00, 3'b010, 1'b1, 1'b1, 8'h40, 1'b0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            add(1'b0, 1'b1, 3'b001, 3'b000, 8'h50, 8'h41, 8'h00, 3'b010, 1'b1, 1'b0, 8'h41, 1'b0, 3'b010);
        end
        add (1'b0, 1'b1, 3'b011, 3'b010, 8'h50, 8'h41, 8'h00, 3'b010, 1'b1, 1'b1, 8'h41, 1'b1, 3'b010);
        idle(1'b0, 1'b1, 3'b001, 3'b001, 8'h50, 8'h00, 8'h00);
        add (1'b0, 1'b1, 3'b001, 3'b001, 8'h50, 8'h00, 8'h00, 3'b001, 1'b1, 1'b1, 8'h50, 1'b1, 3'b001);
        idle(1'b0, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
        // Test 5: reset mid-packet of source 1; pointer returns to source 0.
        idle(1'b0, 1'b1, 3'b011, 3'b000, 8'h60, 8'h70, 8'h00);
        add (1'b0, 1'b1, 3'b011, 3'b000, 8'h60, 8'h70, 8'h00, 3'b010, 1'b1, 1'b1, 8'h70, 1'b0, 3'b010);
        add (1'b1, 1'b0, 3'b011, 3'b000, 8'h60, 8'h71, 8'h00, 3'b010, 1'b1, 1'b1, 8'h71, 1'b0, 3'b000);
        idle(1'b0, 1'b1, 3'b011, 3'b000, 8'h60, 8'h71, 8'h00);
        add (1'b0, 1'b1, 3'b011, 3'b000, 8'h60, 8'h71, 8'h00, 3'b001, 1'b1, 1'b1, 8'h60, 1'b0, 3'b001);
        add (1'b0, 1'b1, 3'b011, 3'b001, 8'h61, 8'h71, 8'h00, 3'b001, 1'b1, 1'b1, 8'h61, 1'b1, 3'b001);
        idle(1'b0, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
        // Test 6: single-beat packets, pointer wrap from 2 to 0.
        idle(1'b0, 1'b1, 3'b100, 3'b100, 8'h00, 8'h00, 8'h7A);
        add (1'b0, 1'b1, 3'b100, 3'b100, 8'h00, 8'h00, 8'h7A, 3'b100, 1'b1, 1'b1, 8'h7A, 1'b1, 3'b100);
        idle(1'b0, 1'b1, 3'b101, 3'b101, 8'h41, 8'h00, 8'h7B);
        add (1'b0, 1'b1, 3'b101, 3'b101, 8'h41, 8'h00, 8'h7B, 3'b001, 1'b1, 1'b1, 8'h41, 1'b1, 3'b001);
        idle(1'b0, 1'b1, 3'b100, 3'b100, 8'h00, 8'h00, 8'h7B);
        add (1'b0, 1'b1, 3'b100, 3'b100, 8'h00, 8'h00, 8'h7B, 3'b100, 1'b1, 1'b1, 8'h7B, 1'b1, 3'b100);
        idle(1'b0, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            rst        = tbl[i].rst;
            sink_ready = tbl[i].rdy;
            msg_valid  = tbl[i].vld;
            msg_last   = tbl[i].lst;
            msg_data   = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
            if (tbl[i].e_vld && tbl[i].rdy) begin
                b.d = tbl[i].e_dat;
                b.l = tbl[i].e_lst;
                sb.push_back(b);
            end
            @(negedge clk);
            chk($sformatf("vec%0d grant", i), 32'(grant),       32'(tbl[i].e_gnt));
            chk($sformatf("vec%0d busy", i),  32'(busy),        32'(tbl[i].e_busy));
            chk($sformatf("vec%0d valid", i), 32'(out_valid),   32'(tbl[i].e_vld));
            chk($sformatf("vec%0d data", i),  32'(out_data),    32'(tbl[i].e_dat));
            chk($sformatf("vec%0d last", i),  32'(out_last),    32'(tbl[i].e_lst));
            chk($sformatf("vec%0d ready", i), 32'(msg_ready_o), 32'(tbl[i].e_rdy));
            if (out_valid && sink_ready) begin
                if (sb.size() == 0) begin
                    chk($sformatf("vec%0d sb_unexpected_beat", i), 32'(1), 32'(0));
                end else begin
                    b = sb.pop_front();
                    chk($sformatf("vec%0d sb_data", i), 32'(out_data), 32'(b.d));
                    chk($sformatf("vec%0d sb_last", i), 32'(out_last), 32'(b.l));
                end
            end
        end
        chk("table sb_drained", 32'(sb.size()), 32'(0));

        // Test 3: sources 0 and 1 compete while sink ready toggles 1,0,1,0.
        b.d = 8'h80; b.l = 1'b0; s0.push_back(b); sb.push_back(b);
        b.d = 8'h81; b.l = 1'b0; s0.push_back(b); sb.push_back(b);
        b.d = 8'h82; b.l = 1'b1; s0.push_back(b); sb.push_back(b);
        b.d = 8'h90; b.l = 1'b0; s1.push_back(b); sb.push_back(b);
        b.d = 8'h91; b.l = 1'b1; s1.push_back(b); sb.push_back(b);
        pop0 = 1'b0;
        pop1 = 1'b0;
        src0_done = 1'b0;
        n_out = 0;
        for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
            @(posedge clk);
            #1;
            if (pop0) void'(s0.pop_front());
            if (pop1) void'(s1.pop_front());
            drive_sources();
            sink_ready = (cyc % 2 == 0);
            @(negedge clk);
            pop0 = msg_ready_o[0] && msg_valid[0];
            pop1 = msg_ready_o[1] && msg_valid[1];
            chk($sformatf("t3 cyc%0d early_grant1", cyc), 32'(grant[1] && !src0_done), 32'(0));
            chk($sformatf("t3 cyc%0d ready_vs_sink", cyc), 32'(msg_ready_o & ~grant), 32'(0));
            if (!sink_ready) begin
                chk($sformatf("t3 cyc%0d stall_ready", cyc), 32'(msg_ready_o), 32'(0));
            end
            if (out_valid && sink_ready) begin
                b = sb.pop_front();
                chk($sformatf("t3 beat%0d data", n_out), 32'(out_data), 32'(b.d));
                chk($sformatf("t3 beat%0d last", n_out), 32'(out_last), 32'(b.l));
                chk($sformatf("t3 beat%0d grant", n_out), 32'(grant), (n_out < 3) ? 32'h1 : 32'h2);
                if (n_out == 2) src0_done = 1'b1;
                n_out++;
            end
        end
        chk("t3 timeout_beats_left", 32'(sb.size()), 32'(0));
        chk("t3 beats_out", 32'(n_out), 32'(5));
        @(posedge clk);
        #1;
        if (pop0) void'(s0.pop_front());
        if (pop1) void'(s1.pop_front());
        chk("t3 src0_drained", 32'(s0.size()), 32'(0));
        chk("t3 src1_drained", 32'(s1.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
